// File: rtl/result_copy_engine.sv
// Copies result-memory words into packed AXI-Stream beats, chunked into write-master transactions.
// Optional beat counter port status_beats is built when RESULT_COPY_STATUS_EN is defined.
module result_copy_engine #(
  parameter int Q_WIDTH     = 64,
  parameter int AXIS_WIDTH  = 512,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_BEATS   = 64,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  kick,
  output logic                  busy,
  input  logic [31:0]           offset,
  input  logic [31:0]           words,
  input  logic [63:0]           memory_addr,
  output logic [31:0]           addr,
  input  logic [Q_WIDTH-1:0]    q,
  output logic                  ctrl_start,
  input  logic                  ctrl_done,
  output logic [63:0]           ctrl_addr_offset,
  output logic [63:0]           ctrl_xfer_size_in_bytes,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [AXIS_WIDTH-1:0] m_axis_tdata
`ifdef RESULT_COPY_STATUS_EN
  , output logic [31:0]         status_beats
`endif
);
  localparam int K  = AXIS_WIDTH / Q_WIDTH;
  localparam int LW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BYTES = AXIS_WIDTH / 8;
  localparam logic [63:0] CHUNK_BYTES = 64'(MAX_BEATS) * 64'(BYTES);

  typedef enum logic [2:0] {IDLE, START, STREAM, WAIT_DONE, FINISH} state_t;
  state_t state;

  logic [31:0] off_l, words_l, remaining, chunk_beats, loaded, sent;
  logic        done_seen;
  logic [31:0] rd_cnt, cons_cnt, fcnt, inflight;
  logic [MEM_LATENCY:0] vld_pipe;
  logic [Q_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [K-1:0][Q_WIDTH-1:0] pack_data, pack_wr;
  logic [LW-1:0] lane;
  logic          pack_full;

  logic handshake, out_free, load_ok, move, pop, push, running, credit_ok, last_word;
  logic rd_go, go_chunk;
  logic [31:0] rd_base, rd_idx, total_c, src_beats, nxt_chunk;
  logic [32:0] words_rnd;
  logic [Q_WIDTH-1:0] fifo_q;

  assign handshake = m_axis_tvalid && m_axis_tready;
  assign out_free  = !m_axis_tvalid || m_axis_tready;
  assign load_ok   = (state == START || state == STREAM) && loaded != chunk_beats && out_free;
  assign move      = pack_full && load_ok;
  assign pop       = fcnt != 0 && (!pack_full || move);
  assign push      = vld_pipe[MEM_LATENCY];
  assign fifo_q    = fifo_mem[rptr];
  assign running   = state == START || state == STREAM || state == WAIT_DONE;
  assign last_word = (lane == LW'(K-1)) || (cons_cnt == words_l - 32'd1);

  assign words_rnd = {1'b0, words} + 33'(K-1);
  assign total_c   = 32'(words_rnd / 33'(K));
  assign src_beats = (state == IDLE) ? total_c : remaining;
  assign nxt_chunk = (src_beats >= 32'(MAX_BEATS)) ? 32'(MAX_BEATS) : src_beats;
  assign go_chunk  = (state == IDLE && kick && words != 0) ||
                     (state == WAIT_DONE && (done_seen || ctrl_done) && remaining != 0);

  // Reads in flight plus buffered words never exceed the buffer, so q is never dropped.
  always_comb begin
    inflight = '0;
    for (int k = 0; k <= MEM_LATENCY; k++) inflight = inflight + 32'(vld_pipe[k]);
  end
  assign credit_ok = (fcnt + inflight) < 32'(FIFO_DEPTH);

  always_comb begin
    rd_go   = 1'b0;
    rd_base = off_l;
    rd_idx  = rd_cnt;
    if (state == IDLE) begin
      rd_base = offset;
      rd_idx  = '0;
      rd_go   = kick && words != 0;
    end else if (running && rd_cnt != words_l && credit_ok) begin
      rd_go = 1'b1;
    end
  end

  // A beat leaving for the output starts the next beat from zero, giving the tail padding.
  always_comb begin
    pack_wr = move ? '0 : pack_data;
    if (pop) pack_wr[lane] = fifo_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy <= 1'b0;
      ctrl_start <= 1'b0;
      ctrl_addr_offset <= '0;
      ctrl_xfer_size_in_bytes <= '0;
      off_l <= '0;
      words_l <= '0;
      remaining <= '0;
      chunk_beats <= '0;
      loaded <= '0;
      sent <= '0;
      done_seen <= 1'b0;
`ifdef RESULT_COPY_STATUS_EN
      status_beats <= '0;
`endif
    end else begin
      ctrl_start <= 1'b0;
      if (move) loaded <= loaded + 32'd1;
      if (handshake) sent <= sent + 32'd1;
      if (ctrl_done && (state == STREAM || state == WAIT_DONE)) done_seen <= 1'b1;
      case (state)
        IDLE: if (kick) begin
          busy <= 1'b1;
          off_l <= offset;
          words_l <= words;
          state <= (words == 0) ? FINISH : START;
        end
        START: state <= STREAM;
        STREAM: if (handshake && sent == chunk_beats - 32'd1) state <= WAIT_DONE;
        WAIT_DONE: if (done_seen || ctrl_done) state <= (remaining == 0) ? FINISH : START;
        FINISH: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (go_chunk) begin
        ctrl_start <= 1'b1;
        chunk_beats <= nxt_chunk;
        remaining <= src_beats - nxt_chunk;
        ctrl_xfer_size_in_bytes <= 64'(nxt_chunk) * 64'(BYTES);
        ctrl_addr_offset <= (state == IDLE) ? memory_addr : ctrl_addr_offset + CHUNK_BYTES;
        loaded <= '0;
        sent <= '0;
        done_seen <= 1'b0;
      end
`ifdef RESULT_COPY_STATUS_EN
      if (state == IDLE && kick) status_beats <= '0;
      else if (handshake) status_beats <= status_beats + 32'd1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr <= '0;
      vld_pipe <= '0;
      rd_cnt <= '0;
      cons_cnt <= '0;
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
      pack_data <= '0;
      lane <= '0;
      pack_full <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
    end else begin
      vld_pipe <= {vld_pipe[MEM_LATENCY-1:0], rd_go};
      if (rd_go) begin
        addr <= rd_base + rd_idx;
        rd_cnt <= rd_idx + 32'd1;
      end
      if (push) wptr <= (wptr == PW'(FIFO_DEPTH-1)) ? '0 : wptr + PW'(1);
      if (pop) rptr <= (rptr == PW'(FIFO_DEPTH-1)) ? '0 : rptr + PW'(1);
      fcnt <= fcnt + 32'(push) - 32'(pop);
      if (pop || move) pack_data <= pack_wr;
      if (pop) begin
        pack_full <= last_word;
        lane <= last_word ? '0 : lane + LW'(1);
        cons_cnt <= cons_cnt + 32'd1;
      end else if (move) begin
        pack_full <= 1'b0;
      end
      if (state == IDLE && kick) begin
        cons_cnt <= '0;
        lane <= '0;
      end
      if (move) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata <= pack_data;
      end else if (handshake) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_result_copy_engine.sv
// Directed bench for result_copy_engine: memory model returns a function of addr, beats checked word by word.
module tb_result_copy_engine;
  localparam int QW = 64, AW = 512, ML = 3, MB = 64, FD = 8, K = AW / QW;

  logic clk, reset_n, kick, busy, ctrl_start, ctrl_done, tvalid, tready;
  logic [31:0] offset, words, addr;
  logic [63:0] memory_addr, cao, cxs;
  logic [QW-1:0] q;
  logic [AW-1:0] tdata;
`ifdef RESULT_COPY_STATUS_EN
  logic [31:0] status_beats;
`endif

  result_copy_engine #(.Q_WIDTH(QW), .AXIS_WIDTH(AW), .MEM_LATENCY(ML), .MAX_BEATS(MB),
                       .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n), .kick(kick), .busy(busy), .offset(offset), .words(words),
    .memory_addr(memory_addr), .addr(addr), .q(q), .ctrl_start(ctrl_start), .ctrl_done(ctrl_done),
    .ctrl_addr_offset(cao), .ctrl_xfer_size_in_bytes(cxs), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tdata(tdata)
`ifdef RESULT_COPY_STATUS_EN
    , .status_beats(status_beats)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Result memory: q(addr) = {addr ^ 5a5a5a5a, addr}, ML cycles after addr.
  logic [31:0] qp [ML];
  always @(posedge clk) begin
    qp[0] <= addr;
    for (int k = 1; k < ML; k++) qp[k] <= qp[k-1];
  end
  assign q = {qp[ML-1] ^ 32'h5a5a_5a5a, qp[ML-1]};

  function automatic logic [63:0] mw(input logic [31:0] a);
    return {a ^ 32'h5a5a_5a5a, a};
  endfunction

  int checks, errors;
  task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int start_cnt, done_cnt, beat_cnt, busy_cyc, chunk_seen, done_cd, rdy_pct, exp_words;
  logic done_pending, late, hold_v;
  logic [31:0] exp_off;
  logic [63:0] sz [8], of [8];
  logic [AW-1:0] held, last_beat, first_beat;

  function automatic logic [AW-1:0] exp_beat(input int b);
    logic [AW-1:0] v;
    v = '0;
    for (int j = 0; j < K; j++)
      if (b * K + j < exp_words) v[j*QW +: QW] = mw(exp_off + 32'(b * K + j));
    return v;
  endfunction

  task automatic mon();
    if (busy) busy_cyc++;
    if (ctrl_done) begin
      done_cnt++;
      done_pending = 0;
    end
    if (ctrl_start) begin
      chk("start_wait_done", done_pending, 0);
      if (start_cnt < 8) begin
        sz[start_cnt] = cxs;
        of[start_cnt] = cao;
      end
      start_cnt++;
      done_pending = 1;
      chunk_seen = 0;
      if (!late) done_cd = 1;
    end
    if (hold_v) begin
      chk("stall_valid", tvalid, 1);
      chk("stall_data", tdata, held);
      hold_v = 0;
    end
    if (tvalid && tready) begin
      chk($sformatf("beat%0d", beat_cnt), tdata, exp_beat(beat_cnt));
      if (beat_cnt == 0) first_beat = tdata;
      last_beat = tdata;
      beat_cnt++;
      chunk_seen++;
      if (late && 64'(chunk_seen) == cxs / 64) done_cd = 50;
    end else if (tvalid) begin
      hold_v = 1;
      held = tdata;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ctrl_done = 0;
    if (done_cd > 0) begin
      done_cd--;
      if (done_cd == 0) ctrl_done = 1;
    end
    tready = ($urandom_range(0, 99) < rdy_pct);
    @(negedge clk);
    mon();
  endtask

  task automatic start_copy(input logic [31:0] o, input logic [31:0] w, input logic [63:0] m);
    offset = o; words = w; memory_addr = m;
    exp_off = o; exp_words = int'(w);
    start_cnt = 0; done_cnt = 0; beat_cnt = 0; busy_cyc = 0; done_pending = 0;
    kick = 1;
    tick();
    kick = 0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    checks = 0; errors = 0; kick = 0; offset = 0; words = 0; memory_addr = 0;
    ctrl_done = 0; tready = 1; rdy_pct = 100; late = 0; done_cd = 0; hold_v = 0;
    done_pending = 0; start_cnt = 0; done_cnt = 0; beat_cnt = 0; busy_cyc = 0; chunk_seen = 0;
    exp_off = 0; exp_words = 0; reset_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_start", ctrl_start, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_addr", addr, 0);
    chk("rst_caddr", cao, 0);
    chk("rst_csize", cxs, 0);
`ifdef RESULT_COPY_STATUS_EN
    chk("rst_status", status_beats, 0);
`endif
    reset_n = 1;
    tick();

    // basic: 2058 words -> 258 beats -> chunks 64,64,64,64,2
    start_copy(32'h0, 32'd2058, 64'habad_cafe_dead_beef);
    chk("basic_busy_rise", busy, 1);
    chk("basic_first_addr", addr, 0);
    wait_idle(6000);
    chk("basic_starts", start_cnt, 5);
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("basic_size%0d", n), sz[n], (n < 4) ? 64'd4096 : 64'd128);
      chk($sformatf("basic_off%0d", n), of[n], 64'habad_cafe_dead_beef + 64'(n) * 64'd4096);
    end
    chk("basic_beats", beat_cnt, 258);
    chk("basic_pad", last_beat[AW-1:128], 0);
    chk("basic_dones", done_cnt, 5);
`ifdef RESULT_COPY_STATUS_EN
    chk("basic_status", status_beats, 258);
`endif

    // packing order across the 32-bit address wrap
    start_copy(32'hffff_fffc, 32'd20, 64'h1000);
    wait_idle(2000);
    chk("pack_beats", beat_cnt, 3);
    chk("pack_size", sz[0], 64'd192);
    chk("pack_w0", first_beat[63:0], 64'ha5a5a5a6_ffff_fffc);
    chk("pack_w1", first_beat[127:64], 64'ha5a5a5a7_ffff_fffd);
    chk("pack_w4", first_beat[319:256], 64'h5a5a5a5a_0000_0000);
    chk("pack_pad", last_beat[AW-1:256], 0);

    // backpressure: ready 30% of cycles
    rdy_pct = 30;
    start_copy(32'h100, 32'd100, 64'h2000);
    wait_idle(5000);
    rdy_pct = 100;
    chk("bp_beats", beat_cnt, 13);
    chk("bp_starts", start_cnt, 1);
    chk("bp_size", sz[0], 64'd832);
`ifdef RESULT_COPY_STATUS_EN
    chk("bp_status", status_beats, 13);
`endif

    // late done: chunk 1 start must wait for the done 50 cycles after chunk 0
    late = 1;
    start_copy(32'h4000, 32'd520, 64'h8000);
    wait_idle(5000);
    late = 0;
    chk("late_starts", start_cnt, 2);
    chk("late_size0", sz[0], 64'd4096);
    chk("late_size1", sz[1], 64'd64);
    chk("late_off1", of[1], 64'h9000);
    chk("late_beats", beat_cnt, 65);
    chk("late_dones", done_cnt, 2);

    // words == 0
    start_copy(32'h0, 32'd0, 64'h0);
    wait_idle(10);
    chk("zero_busy_cyc", busy_cyc, 1);
    chk("zero_starts", start_cnt, 0);

    // kick while busy is ignored
    start_copy(32'h20, 32'd16, 64'h3000);
    tick(); tick();
    offset = 32'h999; words = 32'd500; memory_addr = 64'h0;
    kick = 1;
    tick();
    kick = 0;
    wait_idle(2000);
    chk("kbusy_starts", start_cnt, 1);
    chk("kbusy_beats", beat_cnt, 2);
    chk("kbusy_caddr", cao, 64'h3000);

    // asynchronous reset mid-stream, then a clean copy
    start_copy(32'h0, 32'd200, 64'h5000);
    repeat (20) tick();
    chk("rstm_pre_busy", busy, 1);
    chk("rstm_pre_beats", beat_cnt > 0, 1);
    #2 reset_n = 0;
    hold_v = 0;
    #1;
    chk("rstm_busy", busy, 0);
    chk("rstm_start", ctrl_start, 0);
    chk("rstm_tvalid", tvalid, 0);
    chk("rstm_tdata", tdata, 0);
    chk("rstm_addr", addr, 0);
    chk("rstm_caddr", cao, 0);
    chk("rstm_csize", cxs, 0);
`ifdef RESULT_COPY_STATUS_EN
    chk("rstm_status", status_beats, 0);
`endif
    done_cd = 0;
    tick(); tick();
    reset_n = 1;
    tick();
    start_copy(32'h40, 32'd24, 64'h6000);
    wait_idle(2000);
    chk("rstm_post_beats", beat_cnt, 3);
    chk("rstm_post_starts", start_cnt, 1);
    chk("rstm_post_size", sz[0], 64'd192);
    chk("rstm_post_off", of[0], 64'h6000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
